// File: rtl/crack_par_if.sv
// Host and engine-side signal bundle for the parallel ARC4 key search controller.
// The controller connects to the slave modport; the host/engine side connects to the master modport.
interface crack_par_if #(
    parameter int NUM_ENG = 2,
    parameter int KEY_W   = 24
);
    logic                     en;
    logic                     rdy;
    logic [KEY_W-1:0]         key_lo;
    logic [KEY_W-1:0]         key_hi;
    logic [KEY_W-1:0]         key;
    logic                     key_valid;
    logic [KEY_W:0]           keys_tried;
    logic [NUM_ENG-1:0]       eng_rdy;
    logic [NUM_ENG-1:0]       eng_start;
    logic [NUM_ENG*KEY_W-1:0] eng_key;
    logic [NUM_ENG-1:0]       eng_done;
    logic [NUM_ENG-1:0]       eng_hit;
    logic                     eng_abort;

    modport master (
        output en, key_lo, key_hi, eng_rdy, eng_done, eng_hit,
        input  rdy, key, key_valid, keys_tried, eng_start, eng_key, eng_abort
    );

    modport slave (
        input  en, key_lo, key_hi, eng_rdy, eng_done, eng_hit,
        output rdy, key, key_valid, keys_tried, eng_start, eng_key, eng_abort
    );
endinterface

// File: rtl/crack_par.sv
// Parallel key-search controller: hands consecutive keys to NUM_ENG ARC4 test engines
// and stops on the first printable-plaintext hit, or when the range is exhausted.
module crack_par #(
    parameter int NUM_ENG = 2,
    parameter int KEY_W   = 24
) (
    input logic        clk,
    input logic        rst,
    crack_par_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                   state_q;
    logic [KEY_W:0]           next_key_q;
    logic [KEY_W:0]           keys_tried_q;
    logic [KEY_W-1:0]         key_hi_q;
    logic [KEY_W-1:0]         key_q;
    logic                     key_valid_q;
    logic                     eng_abort_q;
    logic [NUM_ENG-1:0]       busy_q;
    logic [NUM_ENG*KEY_W-1:0] eng_key_q;

    logic [NUM_ENG-1:0]       busy_d;
    logic [NUM_ENG*KEY_W-1:0] eng_key_d;
    logic [NUM_ENG-1:0]       grant;
    logic [NUM_ENG-1:0]       hit_vec;
    logic                     active;
    logic                     any_hit;
    logic                     exhausted;
    logic                     found;
    logic [KEY_W-1:0]         win_key;

    // The extra counter bit lets an all-ones key_hi terminate instead of wrapping.
    always_comb begin
        active    = (state_q == RUN) || (state_q == DRAIN);
        hit_vec   = active ? (bus.eng_done & bus.eng_hit) : '0;
        any_hit   = |hit_vec;
        exhausted = next_key_q > {1'b0, key_hi_q};
        busy_d    = busy_q & ~bus.eng_done;
    end

    always_comb begin
        win_key = '1;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (hit_vec[i] && (eng_key_q[i*KEY_W +: KEY_W] <= win_key)) begin
                win_key = eng_key_q[i*KEY_W +: KEY_W];
            end
        end
    end

    // Start pulse is issued in the dispatch cycle together with its key; a hit in
    // the same cycle suppresses it so nothing starts once the search is decided.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (!rst && (state_q == RUN) && !any_hit && !exhausted) begin
            for (int i = 0; i < NUM_ENG; i++) begin
                if (!found && bus.eng_rdy[i] && !busy_q[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        eng_key_d = eng_key_q;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (grant[i]) begin
                eng_key_d[i*KEY_W +: KEY_W] = next_key_q[KEY_W-1:0];
            end
        end
    end

    assign bus.rdy        = (state_q == IDLE) || (state_q == DONE);
    assign bus.key        = key_q;
    assign bus.key_valid  = key_valid_q;
    assign bus.keys_tried = keys_tried_q;
    assign bus.eng_start  = grant;
    assign bus.eng_key    = eng_key_d;
    assign bus.eng_abort  = eng_abort_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            next_key_q   <= '0;
            keys_tried_q <= '0;
            key_hi_q     <= '0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            eng_abort_q  <= 1'b0;
            busy_q       <= '0;
            eng_key_q    <= '0;
        end else begin
            eng_abort_q <= 1'b0;
            eng_key_q   <= eng_key_d;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.en) begin
                        key_hi_q     <= bus.key_hi;
                        next_key_q   <= {1'b0, bus.key_lo};
                        keys_tried_q <= '0;
                        key_valid_q  <= 1'b0;
                        busy_q       <= '0;
                        state_q      <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (any_hit) begin
                        key_q       <= win_key;
                        key_valid_q <= 1'b1;
                        eng_abort_q <= 1'b1;
                        busy_q      <= '0;
                        state_q     <= DONE;
                    end else if ((state_q == DRAIN) || exhausted) begin
                        busy_q  <= busy_d;
                        state_q <= (busy_d == '0) ? DONE : DRAIN;
                    end else begin
                        busy_q <= busy_d | grant;
                        if (|grant) begin
                            next_key_q   <= next_key_q + (KEY_W+1)'(1);
                            keys_tried_q <= keys_tried_q + (KEY_W+1)'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crack_par.sv
// Self-checking bench for crack_par: behavioural engine models drive the engine side,
// each scenario task checks search results against the key-range rules.
module tb_crack_par;

    localparam int NE = 2;
    localparam int KW = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crack_par_if #(.NUM_ENG(NE), .KEY_W(KW)) bus ();
    crack_par #(.NUM_ENG(NE), .KEY_W(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [KW-1:0] hitKeys[$];
    logic [KW-1:0] dispQ[$];
    int            abortCnt;
    int            badStart;
    int            simulHits;
    bit            randLat;
    int            engLat[NE];

    bit            eBusy[NE];
    int            eCnt[NE];
    logic [KW-1:0] eKey[NE];
    logic [NE-1:0] nd = '0;
    logic [NE-1:0] nh = '0;
    logic [NE-1:0] nr = '1;

    function automatic bit isHit(input logic [KW-1:0] k);
        foreach (hitKeys[j]) if (hitKeys[j] == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit contiguousFrom(input logic [KW-1:0] lo);
        foreach (dispQ[j]) if (dispQ[j] != lo + KW'(j)) return 1'b0;
        return 1'b1;
    endfunction

    // Engine models: observe starts/abort mid-cycle, present done/hit/rdy after the next edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            for (int i = 0; i < NE; i++) eBusy[i] = 1'b0;
            nd = '0; nh = '0; nr = '1;
        end else begin
            if (bus.eng_abort) begin
                abortCnt++;
                for (int i = 0; i < NE; i++) eBusy[i] = 1'b0;
            end
            if ($countones(bus.eng_done & bus.eng_hit) >= 2) simulHits++;
            for (int i = 0; i < NE; i++) if (nd[i]) eBusy[i] = 1'b0;
            for (int i = 0; i < NE; i++) begin
                if (bus.eng_start[i]) begin
                    if (eBusy[i] || abortCnt > 0) badStart++;
                    eBusy[i] = 1'b1;
                    eKey[i]  = bus.eng_key[i*KW +: KW];
                    eCnt[i]  = randLat ? int'($urandom_range(0, 5)) : engLat[i] - 1;
                    dispQ.push_back(eKey[i]);
                end
            end
            for (int i = 0; i < NE; i++) begin
                nd[i] = 1'b0;
                if (eBusy[i]) begin
                    if (eCnt[i] == 0) nd[i] = 1'b1;
                    else eCnt[i]--;
                end
                nh[i] = nd[i] && isHit(eKey[i]);
                nr[i] = !eBusy[i];
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        bus.eng_done = nd;
        bus.eng_hit  = nh;
        bus.eng_rdy  = nr;
    end

    task automatic run_search(input logic [KW-1:0] lo, input logic [KW-1:0] hi, input bit noise,
                              input int budget, output int cyc, output bit timedOut);
        @(posedge clk);
        #1;
        dispQ.delete();
        abortCnt  = 0;
        badStart  = 0;
        simulHits = 0;
        bus.key_lo = lo;
        bus.key_hi = hi;
        bus.en     = 1'b1;
        @(posedge clk);
        #1;
        bus.en   = 1'b0;
        cyc      = 0;
        timedOut = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (bus.rdy) begin
                cyc      = c;
                timedOut = 1'b0;
                break;
            end
            if (noise) begin
                bus.en     = 1'($urandom_range(0, 1));
                bus.key_lo = KW'($urandom);
                bus.key_hi = KW'($urandom);
            end
        end
        bus.en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.key_lo = 24'h000005;
        bus.key_hi = 24'h000009;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.en = 1'b0;
        @(negedge clk);
        checks++; if (bus.rdy !== 1'b1) begin failures++; $display("[TB] FAIL reset_rdy: got %0b expected 1", bus.rdy); end
        checks++; if (bus.key !== '0) begin failures++; $display("[TB] FAIL reset_key: got %0h expected 0", bus.key); end
        checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_key_valid: got %0b expected 0", bus.key_valid); end
        checks++; if (bus.keys_tried !== '0) begin failures++; $display("[TB] FAIL reset_keys_tried: got %0h expected 0", bus.keys_tried); end
        checks++; if (bus.eng_start !== '0) begin failures++; $display("[TB] FAIL reset_eng_start: got %0b expected 0", bus.eng_start); end
        checks++; if (bus.eng_key !== '0) begin failures++; $display("[TB] FAIL reset_eng_key: got %0h expected 0", bus.eng_key); end
        checks++; if (bus.eng_abort !== 1'b0) begin failures++; $display("[TB] FAIL reset_eng_abort: got %0b expected 0", bus.eng_abort); end
    endtask

    task automatic test_single_hit;
        int cyc; bit to;
        randLat = 1'b0; engLat[0] = 3; engLat[1] = 3;
        hitKeys.delete(); hitKeys.push_back(24'h00000B);
        run_search(24'h000000, 24'h00000F, 1'b0, 500, cyc, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL hit_timeout: got timeout expected done"); end
        checks++; if (bus.key !== 24'h00000B) begin failures++; $display("[TB] FAIL hit_key: got %0h expected 00000b", bus.key); end
        checks++; if (bus.key_valid !== 1'b1) begin failures++; $display("[TB] FAIL hit_valid: got %0b expected 1", bus.key_valid); end
        checks++; if (abortCnt != 1) begin failures++; $display("[TB] FAIL hit_abort_pulses: got %0d expected 1", abortCnt); end
        checks++; if (int'(bus.keys_tried) < 12 || int'(bus.keys_tried) > 13) begin
            failures++; $display("[TB] FAIL hit_keys_tried: got %0h expected 0c..0d", bus.keys_tried); end
        checks++; if (!contiguousFrom(24'h0) || dispQ.size() != int'(bus.keys_tried)) begin
            failures++; $display("[TB] FAIL hit_dispatch_list: got %0d keys expected contiguous %0d", dispQ.size(), bus.keys_tried); end
        checks++; if (badStart != 0) begin failures++; $display("[TB] FAIL hit_bad_start: got %0d expected 0", badStart); end
    endtask

    task automatic test_no_hit;
        int cyc; bit to;
        randLat = 1'b0; engLat[0] = 2; engLat[1] = 4;
        hitKeys.delete();
        run_search(24'h000010, 24'h000013, 1'b0, 500, cyc, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL nohit_timeout: got timeout expected done"); end
        checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL nohit_valid: got %0b expected 0", bus.key_valid); end
        checks++; if (int'(bus.keys_tried) != 4) begin failures++; $display("[TB] FAIL nohit_keys_tried: got %0d expected 4", bus.keys_tried); end
        checks++; if (dispQ.size() != 4 || !contiguousFrom(24'h000010)) begin
            failures++; $display("[TB] FAIL nohit_dispatch_list: got %0d keys expected 10..13 once each", dispQ.size()); end
        checks++; if (abortCnt != 0) begin failures++; $display("[TB] FAIL nohit_abort: got %0d expected 0", abortCnt); end
    endtask

    task automatic test_empty_range;
        int cyc; bit to;
        hitKeys.delete();
        run_search(24'h000020, 24'h00001F, 1'b0, 50, cyc, to);
        checks++; if (to || cyc != 2) begin failures++; $display("[TB] FAIL empty_done_cycle: got %0d expected 2", cyc); end
        checks++; if (int'(bus.keys_tried) != 0) begin failures++; $display("[TB] FAIL empty_keys_tried: got %0d expected 0", bus.keys_tried); end
        checks++; if (dispQ.size() != 0) begin failures++; $display("[TB] FAIL empty_starts: got %0d expected 0", dispQ.size()); end
        checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL empty_valid: got %0b expected 0", bus.key_valid); end
    endtask

    task automatic test_simul_hit;
        int cyc; bit to;
        randLat = 1'b0; engLat[0] = 1; engLat[1] = 2;
        hitKeys.delete(); hitKeys.push_back(24'h000035); hitKeys.push_back(24'h000034);
        run_search(24'h000033, 24'h00003F, 1'b0, 200, cyc, to);
        checks++; if (simulHits != 1) begin failures++; $display("[TB] FAIL simul_same_cycle: got %0d expected 1", simulHits); end
        checks++; if (bus.key !== 24'h000034) begin failures++; $display("[TB] FAIL simul_key: got %0h expected 000034", bus.key); end
        checks++; if (bus.key_valid !== 1'b1) begin failures++; $display("[TB] FAIL simul_valid: got %0b expected 1", bus.key_valid); end
        checks++; if (int'(bus.keys_tried) != 3) begin failures++; $display("[TB] FAIL simul_keys_tried: got %0d expected 3", bus.keys_tried); end
    endtask

    task automatic test_top_key;
        int cyc; bit to;
        randLat = 1'b0; engLat[0] = 2; engLat[1] = 2;
        hitKeys.delete();
        run_search(24'hFFFFFF, 24'hFFFFFF, 1'b0, 100, cyc, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL top_timeout: got timeout expected done"); end
        checks++; if (int'(bus.keys_tried) != 1) begin failures++; $display("[TB] FAIL top_keys_tried: got %0d expected 1", bus.keys_tried); end
        checks++; if (dispQ.size() != 1 || dispQ[0] != 24'hFFFFFF) begin
            failures++; $display("[TB] FAIL top_dispatch: got %0d keys expected one ffffff", dispQ.size()); end
        checks++; if (bus.key_valid !== 1'b0) begin failures++; $display("[TB] FAIL top_valid: got %0b expected 0", bus.key_valid); end
    endtask

    task automatic test_reset_mid;
        int cyc; bit to; bit reached;
        randLat = 1'b0; engLat[0] = 4; engLat[1] = 4;
        hitKeys.delete();
        @(posedge clk);
        #1;
        dispQ.delete(); abortCnt = 0;
        bus.key_lo = 24'h0; bus.key_hi = 24'hFF; bus.en = 1'b1;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (dispQ.size() >= 5) begin reached = 1'b1; break; end
        end
        checks++; if (!reached) begin failures++; $display("[TB] FAIL rstmid_dispatches: got %0d expected 5", dispQ.size()); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.rdy !== 1'b1 || bus.key_valid !== 1'b0 || bus.keys_tried !== '0 || bus.key !== '0) begin
            failures++; $display("[TB] FAIL rstmid_status: got rdy=%0b valid=%0b tried=%0h key=%0h expected 1/0/0/0",
                                 bus.rdy, bus.key_valid, bus.keys_tried, bus.key); end
        checks++; if (bus.eng_start !== '0 || bus.eng_key !== '0 || bus.eng_abort !== 1'b0) begin
            failures++; $display("[TB] FAIL rstmid_engine_side: got start=%0b key=%0h abort=%0b expected 0", bus.eng_start, bus.eng_key, bus.eng_abort); end
        checks++; if (abortCnt != 0) begin failures++; $display("[TB] FAIL rstmid_abort: got %0d expected 0", abortCnt); end
        run_search(24'h0, 24'h3, 1'b0, 200, cyc, to);
        checks++; if (to || dispQ.size() == 0 || dispQ[0] != 24'h0) begin
            failures++; $display("[TB] FAIL rstmid_restart_key: got %0d keys expected first key 0", dispQ.size()); end
        checks++; if (int'(bus.keys_tried) != 4) begin failures++; $display("[TB] FAIL rstmid_restart_tried: got %0d expected 4", bus.keys_tried); end
    endtask

    // Random ranges, hit sets and latencies, with en noise while busy; results follow from range rules.
    task automatic test_random;
        int cyc; bit to;
        randLat = 1'b1;
        for (int it = 0; it < 12; it++) begin
            int lo, span, hi, nHits, expTried;
            bit expValid, keyOk;
            lo    = int'($urandom_range(3, 200));
            span  = int'($urandom_range(0, 34));
            hi    = lo + span - 2;
            nHits = int'($urandom_range(0, 3));
            hitKeys.delete();
            for (int h = 0; h < nHits; h++) hitKeys.push_back(KW'(lo - 3 + int'($urandom_range(0, span + 4))));
            expValid = 1'b0;
            foreach (hitKeys[j]) if (int'(hitKeys[j]) >= lo && int'(hitKeys[j]) <= hi) expValid = 1'b1;
            expTried = (hi >= lo) ? hi - lo + 1 : 0;
            run_search(KW'(lo), KW'(hi), 1'b1, 3000, cyc, to);
            checks++; if (to) begin failures++; $display("[TB] FAIL rand%0d_timeout: got timeout expected done", it); end
            checks++; if (bus.key_valid !== expValid) begin
                failures++; $display("[TB] FAIL rand%0d_valid: got %0b expected %0b", it, bus.key_valid, expValid); end
            checks++; if (dispQ.size() != int'(bus.keys_tried) || !contiguousFrom(KW'(lo))) begin
                failures++; $display("[TB] FAIL rand%0d_dispatch: got %0d keys tried=%0d expected contiguous from %0h", it, dispQ.size(), bus.keys_tried, lo); end
            if (expValid) begin
                keyOk = isHit(bus.key) && int'(bus.key) >= lo && int'(bus.key) <= hi;
                checks++; if (!keyOk || abortCnt != 1) begin
                    failures++; $display("[TB] FAIL rand%0d_hit: got key=%0h aborts=%0d expected hit key in range, 1 abort", it, bus.key, abortCnt); end
            end else begin
                checks++; if (int'(bus.keys_tried) != expTried || abortCnt != 0) begin
                    failures++; $display("[TB] FAIL rand%0d_exhaust: got tried=%0d aborts=%0d expected %0d, 0", it, bus.keys_tried, abortCnt, expTried); end
            end
            checks++; if (badStart != 0) begin failures++; $display("[TB] FAIL rand%0d_bad_start: got %0d expected 0", it, badStart); end
        end
    endtask

    initial begin
        bus.en = 1'b0;
        bus.key_lo = '0;
        bus.key_hi = '0;
        randLat = 1'b0;
        engLat[0] = 1;
        engLat[1] = 1;
        test_reset;
        test_single_hit;
        test_no_hit;
        test_empty_range;
        test_simul_hit;
        test_top_key;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
